// File: rtl/axe_pulse_to_stream_if.sv
// axe_pulse_to_stream_if: valid/ready beat stream carrying one data word per handshake
interface axe_pulse_to_stream_if #(parameter int DataWidth = 32);
   logic [DataWidth-1:0] oup_data;
   logic                 oup_valid;
   logic                 oup_ready;
   modport master (output oup_data, output oup_valid, input oup_ready);
   modport slave (input oup_data, input oup_valid, output oup_ready);
endinterface

// File: rtl/axe_pulse_to_stream.sv
// axe_pulse_to_stream: buffers nonzero input pulses in a FIFO and emits them as a valid/ready stream,
// with occupancy, overflow, beat counters and largest inter-beat idle gap.
module axe_pulse_to_stream #(
   parameter int DataWidth = 32,
   parameter int Depth     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DataWidth-1:0]     inp,
   input  logic                     flush,
   axe_pulse_to_stream_if.master    oup,
   output logic [$clog2(Depth):0]   level,
   output logic                     overflow,
   output logic [31:0]              beats_in,
   output logic [31:0]              beats_out,
   output logic [31:0]              drops,
   output logic [15:0]              gap_max
);
   localparam int AW = $clog2(Depth);
   localparam int LW = AW + 1;
   logic [DataWidth-1:0] mem [Depth];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [15:0]          idle;
   logic                 seen;
   logic                 beat, full, pop, push, drop;
   assign beat          = |inp;
   assign full          = level == LW'(Depth);
   assign pop           = oup.oup_valid && oup.oup_ready;
   // a full FIFO still takes a beat when the head leaves in the same cycle
   assign push          = beat && !flush && (!full || pop);
   assign drop          = beat && !push;
   assign oup.oup_valid = level != '0;
   assign oup.oup_data  = oup.oup_valid ? mem[rd_ptr] : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < Depth; i++) mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         beats_in  <= '0;
         beats_out <= '0;
         drops     <= '0;
         gap_max   <= '0;
         idle      <= '0;
         seen      <= 1'b0;
      end else begin
         if (push) mem[wr_ptr] <= inp;
         wr_ptr    <= flush ? '0 : wr_ptr + AW'(push);
         rd_ptr    <= flush ? '0 : rd_ptr + AW'(pop);
         level     <= flush ? '0 : level + LW'(push) - LW'(pop);
         overflow  <= !flush && (overflow || (beat && full && !pop));
         beats_in  <= beats_in + 32'(push);
         beats_out <= beats_out + 32'(pop && !flush);
         drops     <= drops + 32'(drop);
         // the idle run before the very first beat is not a gap between beats
         gap_max   <= (beat && seen && idle > gap_max) ? idle : gap_max;
         idle      <= beat ? '0 : (idle == 16'hFFFF ? idle : idle + 16'd1);
         seen      <= seen || beat;
      end
   end
endmodule

// File: tb/tb_axe_pulse_to_stream.sv
// tb_axe_pulse_to_stream: directed vectors with hand-computed expectations for the pulse-to-stream FIFO
module tb_axe_pulse_to_stream;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] inp = '0;
   logic        flush = 1'b0;
   logic [3:0]  level;
   logic        overflow;
   logic [31:0] beats_in, beats_out, drops;
   logic [15:0] gap_max;
   int          n_tests = 0;
   int          n_fail = 0;
   axe_pulse_to_stream_if #(.DataWidth(32)) s ();
   axe_pulse_to_stream #(.DataWidth(32), .Depth(8)) dut (
      .clk(clk), .rst_n(rst_n), .inp(inp), .flush(flush), .oup(s),
      .level(level), .overflow(overflow), .beats_in(beats_in),
      .beats_out(beats_out), .drops(drops), .gap_max(gap_max)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic beat(input logic [31:0] v);
      inp = v;
      tick();
      inp = '0;
   endtask
   initial begin
      s.oup_ready = 1'b0;
      repeat (2) tick();
      check("rst_level", 32'(level), 0);
      check("rst_valid", 32'(s.oup_valid), 0);
      check("rst_data", s.oup_data, 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_cnt", beats_in | beats_out | drops, 0);
      check("rst_gap", 32'(gap_max), 0);
      rst_n = 1'b1;
      tick();
      // single beat, consumer ready
      s.oup_ready = 1'b1;
      beat(32'h5);
      check("single_valid", 32'(s.oup_valid), 1);
      check("single_data", s.oup_data, 32'h5);
      check("single_in", beats_in, 1);
      tick();
      check("single_empty", 32'(s.oup_valid), 0);
      check("single_data0", s.oup_data, 0);
      check("single_out", beats_out, 1);
      // fill past full with the consumer stalled
      s.oup_ready = 1'b0;
      for (int v = 1; v <= 9; v++) beat(32'(v));
      check("full_level", 32'(level), 8);
      check("full_drops", drops, 1);
      check("full_ovf", 32'(overflow), 1);
      check("full_head", s.oup_data, 1);
      tick();
      check("stall_head", s.oup_data, 1);
      // push into full FIFO while the head leaves
      s.oup_ready = 1'b1;
      beat(32'hA);
      check("pp_level", 32'(level), 8);
      check("pp_drops", drops, 1);
      for (int k = 2; k <= 8; k++) begin
         check($sformatf("order_%0d", k), s.oup_data, 32'(k));
         tick();
      end
      check("order_A", s.oup_data, 32'hA);
      tick();
      check("drain_valid", 32'(s.oup_valid), 0);
      check("drain_in", beats_in, 10);
      check("drain_out", beats_out, 10);
      check("drain_ovf_sticky", 32'(overflow), 1);
      // flush with a beat and a would-be pop in the same cycle
      s.oup_ready = 1'b0;
      for (int v = 1; v <= 5; v++) beat(32'(v));
      check("pre_flush_level", 32'(level), 5);
      s.oup_ready = 1'b1;
      flush = 1'b1;
      beat(32'hB);
      flush = 1'b0;
      s.oup_ready = 1'b0;
      check("flush_level", 32'(level), 0);
      check("flush_valid", 32'(s.oup_valid), 0);
      check("flush_ovf", 32'(overflow), 0);
      check("flush_drops", drops, 2);
      check("flush_in", beats_in, 15);
      check("flush_out", beats_out, 10);
      // asynchronous reset mid-operation
      beat(32'h11);
      beat(32'h12);
      beat(32'h13);
      check("prerst_level", 32'(level), 3);
      #2 rst_n = 1'b0;
      #1;
      check("arst_level", 32'(level), 0);
      check("arst_valid", 32'(s.oup_valid), 0);
      check("arst_data", s.oup_data, 0);
      check("arst_cnt", beats_in | beats_out | drops, 0);
      check("arst_gap", 32'(gap_max), 0);
      tick();
      rst_n = 1'b1;
      beat(32'hC);
      check("post_rst_head", s.oup_data, 32'hC);
      check("post_rst_level", 32'(level), 1);
      check("post_rst_in", beats_in, 1);
      // idle gaps, starting from a fresh reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      s.oup_ready = 1'b1;
      repeat (5) tick();
      beat(32'h1);
      check("gap_first", 32'(gap_max), 0);
      repeat (3) tick();
      check("gap_pending", 32'(gap_max), 0);
      beat(32'h2);
      check("gap_3", 32'(gap_max), 3);
      repeat (7) tick();
      beat(32'h3);
      check("gap_7", 32'(gap_max), 7);
      repeat (2) tick();
      beat(32'h4);
      check("gap_keep", 32'(gap_max), 7);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/axe_pulse_to_stream.md
AXE_PULSE_TO_STREAM -- requirements
Module: axe_pulse_to_stream

Interface
REQ-001 SHALL have parameter DataWidth, default 32: width of data beat.
REQ-002 SHALL have parameter Depth, default 8: FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port inp  input  DataWidth: pulse-encoded input stream; nonzero = one beat, all-zero = idle.
REQ-006 SHALL have port flush  input  1: synchronous clear of buffered beats.
REQ-007 SHALL have port oup_data  output  DataWidth: FIFO head beat.
REQ-008 SHALL have port oup_valid  output  1: oup_data holds a beat.
REQ-009 SHALL have port oup_ready  input  1: consumer accepts the beat.
REQ-010 SHALL have port level  output  $clog2(Depth)+1: current FIFO occupancy.
REQ-011 SHALL have port overflow  output  1: sticky; a beat was dropped on full.
REQ-012 SHALL have port beats_in  output  32: accepted input beats.
REQ-013 SHALL have port beats_out  output  32: beats handed off (valid && ready).
REQ-014 SHALL have port drops  output  32: input beats discarded.
REQ-015 SHALL have port gap_max  output  16: largest idle gap seen between consecutive input beats.

Function
REQ-016 SHALL treat inp as a beat on any clk edge where |inp == 1.
REQ-017 SHALL push an input beat when level < Depth, or when level == Depth and a pop occurs the same cycle.
REQ-018 SHALL assert oup_valid iff level != 0; oup_data = oldest entry; oup_data = '0 when level == 0.
REQ-019 SHALL pop on valid && ready; beat pushed at edge N is visible on oup_valid after edge N (one-cycle latency, no bypass).
REQ-020 SHALL keep oup_data/oup_valid stable while oup_valid && !oup_ready, except on flush.
REQ-021 SHALL, on a beat with level == Depth and no pop, discard it, increment drops, set overflow, leave FIFO unchanged.
REQ-022 SHALL, on simultaneous push and pop, keep level unchanged and preserve order.
REQ-023 SHALL wrap read/write pointers modulo Depth; FIFO order strictly first-in first-out.
REQ-024 SHALL, on flush == 1, set level to 0 and clear overflow at the next edge; an input beat that cycle is discarded and counted in drops; a pop that cycle is not counted in beats_out.
REQ-025 SHALL increment beats_in per pushed beat and beats_out per pop; all 32-bit counters wrap from 2^32-1 to 0; flush does not clear counters.
REQ-026 SHALL count idle cycles since the last beat (saturating at 16'hFFFF) and, on each beat after the first since reset, set gap_max = max(gap_max, idle count), then zero the idle count.
REQ-027 SHALL ignore gap before the first beat after reset.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear FIFO, pointers, level, oup_valid, oup_data, overflow, beats_in, beats_out, drops, gap_max, idle count and first-beat flag to 0.
REQ-029 SHALL discard buffered beats on reset mid-operation; first edge after release behaves as empty FIFO.

Verification
REQ-030 Single beat inp=0x5 at edge 1, oup_ready=1 -> oup_valid=1, oup_data=0x5 for one cycle after edge 1; beats_in=beats_out=1.
REQ-031 Depth=8, oup_ready=0, 9 consecutive beats 1..9 -> level=8, drops=1, overflow=1, beat 9 lost; then ready=1 -> outputs 1..8 in order.
REQ-032 Full FIFO, oup_ready=1, beat 0xA same cycle -> accepted, level stays 8, drops unchanged, 0xA emerges eighth.
REQ-033 Beats at edges 0, 4, 12 -> gap_max=3 then 7.
REQ-034 Level=5, overflow=1, flush=1 with beat 0xB -> level=0, oup_valid=0, overflow=0, drops+1, beats_in unchanged.
REQ-035 rst_n low with level=3 for one cycle -> all outputs 0 asynchronously; next beat 0xC emerges first.
